// File: rtl/rgmii_pkg.sv
// Shared constants and types for the RGMII transmit encoder: speed codes,
// 10/100 divider lengths, TXC high-phase lengths and the captured-byte record.
package rgmii_pkg;

  localparam int CNT_W = 6;

  typedef enum logic [1:0] {
    SPEED_10   = 2'b00,
    SPEED_100  = 2'b01,
    SPEED_1000 = 2'b10
  } speed_e;

  localparam logic [CNT_W-1:0] DIV_100  = 6'd5;
  localparam logic [CNT_W-1:0] DIV_10   = 6'd50;
  // TXC is (1,1) for cnt below the high length; at 100 the cnt==HIGH_100 slot is (1,0).
  localparam logic [CNT_W-1:0] HIGH_100 = 6'd2;
  localparam logic [CNT_W-1:0] HIGH_10  = 6'd25;

  typedef struct packed {
    logic       en;
    logic       er;
    logic [7:0] data;
  } gmii_byte_t;

  // 2'b11 is deliberately folded into gigabit.
  function automatic logic is_gig(input logic [1:0] s);
    return s[1];
  endfunction

  function automatic logic [CNT_W-1:0] div_last(input logic [1:0] s);
    return (s == SPEED_100) ? (DIV_100 - CNT_W'(1)) : (DIV_10 - CNT_W'(1));
  endfunction

endpackage

// File: rtl/rgmii_tx_clk_gen.sv
// Speed latch, 10/100 nibble divider, MAC byte strobe and TXC edge pattern.
// Exposes next-cycle mode and nibble select so the data path stays aligned.
module rgmii_tx_clk_gen
  import rgmii_pkg::*;
#(
  parameter logic [1:0] SPEED_RESET = 2'b10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] speed,
  output logic       gmii_clk_en,
  output logic       txc_d1,
  output logic       txc_d2,
  output logic       gig_d,
  output logic       nib_sel_d
);

  logic [1:0]       speed_q, speed_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             nib_sel_q;
  logic             clk_en_q, clk_en_d;
  logic             txc_d1_q, txc_d1_d;
  logic             txc_d2_q, txc_d2_d;
  logic             boundary;

  always_comb begin
    speed_d   = speed_q;
    cnt_d     = cnt_q;
    nib_sel_d = nib_sel_q;
    boundary  = is_gig(speed_q) || (nib_sel_q && (cnt_q == div_last(speed_q)));
    if (boundary) begin
      speed_d   = speed;
      cnt_d     = '0;
      nib_sel_d = 1'b0;
    end else if (cnt_q == div_last(speed_q)) begin
      cnt_d     = '0;
      nib_sel_d = ~nib_sel_q;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    // Strobe and TXC are decoded from the next state so they land registered.
    gig_d    = is_gig(speed_d);
    clk_en_d = gig_d || (nib_sel_d && (cnt_d == div_last(speed_d)));
    if (gig_d) begin
      txc_d1_d = 1'b1;
      txc_d2_d = 1'b0;
    end else if (speed_d == SPEED_100) begin
      txc_d1_d = (cnt_d <= HIGH_100);
      txc_d2_d = (cnt_d <  HIGH_100);
    end else begin
      txc_d1_d = (cnt_d < HIGH_10);
      txc_d2_d = (cnt_d < HIGH_10);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      speed_q   <= SPEED_RESET;
      cnt_q     <= '0;
      nib_sel_q <= 1'b0;
      clk_en_q  <= 1'b0;
      txc_d1_q  <= 1'b0;
      txc_d2_q  <= 1'b0;
    end else begin
      speed_q   <= speed_d;
      cnt_q     <= cnt_d;
      nib_sel_q <= nib_sel_d;
      clk_en_q  <= clk_en_d;
      txc_d1_q  <= txc_d1_d;
      txc_d2_q  <= txc_d2_d;
    end
  end

  assign gmii_clk_en = clk_en_q;
  assign txc_d1      = txc_d1_q;
  assign txc_d2      = txc_d2_q;

endmodule

// File: rtl/rgmii_tx_encoder.sv
// GMII byte stream to RGMII ODDR data pairs at 1000/100/10 Mbps.
// Optional saturating error-byte counter built when RGMII_TX_ERR_CNT_EN is defined.
module rgmii_tx_encoder
  import rgmii_pkg::*;
#(
  parameter logic [1:0] SPEED_RESET = 2'b10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  speed,
  input  logic [7:0]  gmii_txd,
  input  logic        gmii_tx_en,
  input  logic        gmii_tx_er,
  output logic        gmii_clk_en,
  output logic [3:0]  txd_d1,
  output logic [3:0]  txd_d2,
  output logic        txctl_d1,
  output logic        txctl_d2,
  output logic        txc_d1,
  output logic        txc_d2,
  output logic [15:0] tx_err_count
);

  logic       gig_d, nib_sel_d;
  gmii_byte_t byte_q, byte_d;
  logic [3:0] txd_d1_q, txd_d1_d, txd_d2_q, txd_d2_d, nib;
  logic       txctl_d1_q, txctl_d1_d, txctl_d2_q, txctl_d2_d;

  rgmii_tx_clk_gen #(.SPEED_RESET(SPEED_RESET)) u_clk_gen (
    .clk         (clk),
    .rst         (rst),
    .speed       (speed),
    .gmii_clk_en (gmii_clk_en),
    .txc_d1      (txc_d1),
    .txc_d2      (txc_d2),
    .gig_d       (gig_d),
    .nib_sel_d   (nib_sel_d)
  );

  always_comb begin
    byte_d = byte_q;
    // Idle bytes are forced to zero data; extend/error bytes pass through.
    if (gmii_clk_en) begin
      byte_d.en   = gmii_tx_en;
      byte_d.er   = gmii_tx_er;
      byte_d.data = (gmii_tx_en || gmii_tx_er) ? gmii_txd : 8'h00;
    end
    nib        = nib_sel_d ? byte_d.data[7:4] : byte_d.data[3:0];
    txd_d1_d   = gig_d ? byte_d.data[3:0] : nib;
    txd_d2_d   = gig_d ? byte_d.data[7:4] : nib;
    txctl_d1_d = byte_d.en;
    txctl_d2_d = byte_d.en ^ byte_d.er;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_q     <= '0;
      txd_d1_q   <= '0;
      txd_d2_q   <= '0;
      txctl_d1_q <= 1'b0;
      txctl_d2_q <= 1'b0;
    end else begin
      byte_q     <= byte_d;
      txd_d1_q   <= txd_d1_d;
      txd_d2_q   <= txd_d2_d;
      txctl_d1_q <= txctl_d1_d;
      txctl_d2_q <= txctl_d2_d;
    end
  end

  assign txd_d1   = txd_d1_q;
  assign txd_d2   = txd_d2_q;
  assign txctl_d1 = txctl_d1_q;
  assign txctl_d2 = txctl_d2_q;

`ifdef RGMII_TX_ERR_CNT_EN
  logic [15:0] err_cnt_q, err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (gmii_clk_en && gmii_tx_er && (err_cnt_q != 16'hFFFF))
      err_cnt_d = err_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_cnt_q <= '0;
    else     err_cnt_q <= err_cnt_d;
  end

  assign tx_err_count = err_cnt_q;
`else
  assign tx_err_count = '0;
`endif

endmodule

// File: tb/tb_rgmii_tx_encoder.sv
// Directed scoreboard bench for rgmii_tx_encoder: 1000/100/10 data and TXC,
// control encoding, mid-byte speed change and mid-frame reset.
module tb_rgmii_tx_encoder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  speed = 2'b10;
  logic [7:0]  gmii_txd = 8'h00;
  logic        gmii_tx_en = 1'b0;
  logic        gmii_tx_er = 1'b0;
  logic        gmii_clk_en;
  logic [3:0]  txd_d1, txd_d2;
  logic        txctl_d1, txctl_d2, txc_d1, txc_d2;
  logic [15:0] tx_err_count;

  int n_tests = 0;
  int n_fail  = 0;
  logic [12:0] sb[$];

  always #4 clk = ~clk;

  rgmii_tx_encoder dut (
    .clk          (clk),
    .rst          (rst),
    .speed        (speed),
    .gmii_txd     (gmii_txd),
    .gmii_tx_en   (gmii_tx_en),
    .gmii_tx_er   (gmii_tx_er),
    .gmii_clk_en  (gmii_clk_en),
    .txd_d1       (txd_d1),
    .txd_d2       (txd_d2),
    .txctl_d1     (txctl_d1),
    .txctl_d2     (txctl_d2),
    .txc_d1       (txc_d1),
    .txc_d2       (txc_d2),
    .tx_err_count (tx_err_count)
  );

  // {clk_en, txc_d1, txc_d2, txd_d1, txd_d2, txctl_d1, txctl_d2}
  function automatic logic [12:0] obs_vec();
    return {gmii_clk_en, txc_d1, txc_d2, txd_d1, txd_d2, txctl_d1, txctl_d2};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] txc_exp(input int n, input int c);
    if (n == 5) return (c < 2) ? 2'b11 : ((c == 2) ? 2'b10 : 2'b00);
    return (c < 25) ? 2'b11 : 2'b00;
  endfunction

  // Presents one byte on a strobe cycle; n=0 means gigabit, else N of the divider.
  task automatic send_byte(input string tag, input logic [7:0] b, input logic en,
                           input logic er, input int n, input int chg_at,
                           input logic [1:0] chg_spd);
    logic [7:0]  v;
    logic [3:0]  nb;
    logic [12:0] e, got;
    int          cnt;
    chk({tag, "_strobe_ready"}, gmii_clk_en, 1'b1);
    gmii_txd = b; gmii_tx_en = en; gmii_tx_er = er;
    v = (en || er) ? b : 8'h00;
    if (n == 0) begin
      sb.push_back({1'b1, 2'b10, v[3:0], v[7:4], en, en ^ er});
    end else begin
      for (int j = 0; j < 2 * n; j++) begin
        nb = (j < n) ? v[3:0] : v[7:4];
        sb.push_back({(j == 2 * n - 1), txc_exp(n, j % n), nb, nb, en, en ^ er});
      end
    end
    cnt = sb.size();
    for (int j = 0; j < cnt; j++) begin
      @(negedge clk);
      if (j == 0) begin
        gmii_txd = 8'h00; gmii_tx_en = 1'b0; gmii_tx_er = 1'b0;
      end
      if (j == chg_at) speed = chg_spd;
      e   = sb.pop_front();
      got = obs_vec();
      n_tests++;
      assert (got === e)
      else begin
        n_fail++;
        $error("FAIL %s[%0d]: observed en/txc/d1/d2/ctl=%0h expected %0h", tag, j, got, e);
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int   k;
    logic leak;

    repeat (2) @(negedge clk);
    chk("reset_outputs", {19'd0, obs_vec()}, 32'd0);
    chk("reset_err_count", tx_err_count, 16'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("first_strobe_1000", gmii_clk_en, 1'b1);
    chk("first_txd_idle", {txd_d1, txd_d2, txctl_d1, txctl_d2}, 10'd0);

    send_byte("g_a5",   8'hA5, 1'b1, 1'b0, 0, -1, 2'b10);
    send_byte("g_ext",  8'h3C, 1'b0, 1'b1, 0, -1, 2'b10);
    send_byte("g_err",  8'hF0, 1'b1, 1'b1, 0, -1, 2'b10);
    send_byte("g_idle", 8'h55, 1'b0, 1'b0, 0, -1, 2'b10);

    speed = 2'b01;
    send_byte("to100",  8'h00, 1'b0, 1'b0, 5, -1, 2'b01);
    send_byte("f_3c",   8'h3C, 1'b1, 1'b0, 5, -1, 2'b01);
    send_byte("f_ext",  8'h96, 1'b0, 1'b1, 5, -1, 2'b01);
`ifdef RGMII_TX_ERR_CNT_EN
    chk("err_count_3", tx_err_count, 16'd3);
`else
    chk("err_count_off", tx_err_count, 16'd0);
`endif

    send_byte("f_chg",  8'h7E, 1'b1, 1'b0, 5, 2, 2'b10);
    send_byte("g_81",   8'h81, 1'b1, 1'b0, 0, -1, 2'b10);

    speed = 2'b00;
    send_byte("t_d2",   8'hD2, 1'b1, 1'b0, 50, -1, 2'b00);

    speed = 2'b01;
    send_byte("back100", 8'h00, 1'b0, 1'b0, 5, -1, 2'b01);
    chk("rst_pre_strobe", gmii_clk_en, 1'b1);
    gmii_txd = 8'h5A; gmii_tx_en = 1'b1;
    repeat (3) @(negedge clk);
    gmii_txd = 8'h00; gmii_tx_en = 1'b0;
    chk("rst_pre_low_nib", {txd_d1, txd_d2}, 8'hAA);
    rst = 1'b1;
    #1;
    chk("rst_async_outputs", {19'd0, obs_vec()}, 32'd0);
    chk("rst_async_err", tx_err_count, 16'd0);
    @(negedge clk);
    rst = 1'b0;
    k = 0;
    leak = 1'b0;
    while (k < 30) begin
      @(negedge clk);
      k++;
      if (gmii_clk_en) break;
      leak = leak | (|{txd_d1, txd_d2, txctl_d1, txctl_d2});
    end
    chk("rst_first_strobe_cycle", k, 10);
    chk("rst_partial_dropped", leak, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
